// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU encodings and datapath width defaults
package cpu_pkg;

    localparam int DEFAULT_XLEN = 32;
    localparam int DEFAULT_RA_W = 5;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SLL  = 3'b001,
        ALU_SUB  = 3'b010,
        ALU_MUL  = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_SRA  = 3'b101,
        ALU_NONE = 3'b110,
        ALU_AND  = 3'b111
    } alu_op_e;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/forwarding_unit.sv
// rtl/forwarding_unit.sv - EX operand forward-select generation from the MEM/WB write ports
module forwarding_unit
    import cpu_pkg::*;
#(
    parameter int RA_W = DEFAULT_RA_W
) (
    input  logic            ex_valid,
    input  logic [RA_W-1:0] ex_rs1,
    input  logic [RA_W-1:0] ex_rs2,
    input  logic            mem_reg_write,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            wb_reg_write,
    input  logic [RA_W-1:0] wb_rd,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b
);

    // The younger producer (MEM) wins; x0 is hard-wired zero and never bypassed.
    function automatic logic [1:0] select_src(
        input logic            valid,
        input logic [RA_W-1:0] rs,
        input logic            m_we,
        input logic [RA_W-1:0] m_rd,
        input logic            w_we,
        input logic [RA_W-1:0] w_rd
    );
        if (!valid || rs == '0)
            return FWD_REG;
        if (m_we && m_rd == rs)
            return FWD_MEM;
        if (w_we && w_rd == rs)
            return FWD_WB;
        return FWD_REG;
    endfunction

    assign fwd_a = select_src(ex_valid, ex_rs1, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
    assign fwd_b = select_src(ex_valid, ex_rs2, mem_reg_write, mem_rd, wb_reg_write, wb_rd);

endmodule

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX pipeline register with load-use stall and ALU operand forwarding
module id_ex_operand_stage
    import cpu_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN,
    parameter int RA_W = DEFAULT_RA_W
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            id_valid_i,
    input  logic [XLEN-1:0] id_rs1_data_i,
    input  logic [XLEN-1:0] id_rs2_data_i,
    input  logic [XLEN-1:0] id_imm_i,
    input  logic [RA_W-1:0] id_rs1_addr_i,
    input  logic [RA_W-1:0] id_rs2_addr_i,
    input  logic [RA_W-1:0] id_rd_addr_i,
    input  logic [2:0]      id_alu_op_i,
    input  logic            id_alu_src_i,
    input  logic            id_reg_write_i,
    input  logic            id_mem_to_reg_i,
    input  logic            id_mem_read_i,
    input  logic            id_mem_write_i,
    input  logic            mem_reg_write_i,
    input  logic [RA_W-1:0] mem_rd_addr_i,
    input  logic [XLEN-1:0] mem_alu_result_i,
    input  logic            wb_reg_write_i,
    input  logic [RA_W-1:0] wb_rd_addr_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic            stall_o,
    output logic [XLEN-1:0] ex_data1_o,
    output logic [XLEN-1:0] ex_data2_o,
    output logic [2:0]      ex_alu_op_o,
    output logic [XLEN-1:0] ex_store_data_o,
    output logic [RA_W-1:0] ex_rd_addr_o,
    output logic            ex_valid_o,
    output logic            ex_reg_write_o,
    output logic            ex_mem_to_reg_o,
    output logic            ex_mem_read_o,
    output logic            ex_mem_write_o,
    output logic [1:0]      fwd_a_o,
    output logic [1:0]      fwd_b_o
);

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            mem_to_reg;
        logic            mem_read;
        logic            mem_write;
        logic            alu_src;
        logic [2:0]      alu_op;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
    } id_ex_t;

    id_ex_t          ex_q;
    id_ex_t          id_d;
    logic            bubble;
    logic [XLEN-1:0] fwd_b_data;

    // A load in EX cannot feed a consumer in ID in time; hold ID one cycle.
    assign stall_o = ex_q.valid && ex_q.mem_read && ex_q.rd != '0
                     && id_valid_i && !flush_i
                     && (ex_q.rd == id_rs1_addr_i || ex_q.rd == id_rs2_addr_i);
    assign bubble  = flush_i || stall_o || !id_valid_i;

    always_comb begin
        id_d = '0;
        if (!bubble) begin
            id_d.valid      = 1'b1;
            id_d.reg_write  = id_reg_write_i;
            id_d.mem_to_reg = id_mem_to_reg_i;
            id_d.mem_read   = id_mem_read_i;
            id_d.mem_write  = id_mem_write_i;
            id_d.alu_src    = id_alu_src_i;
            id_d.alu_op     = id_alu_op_i;
            id_d.rs1        = id_rs1_addr_i;
            id_d.rs2        = id_rs2_addr_i;
            id_d.rd         = id_rd_addr_i;
            id_d.rs1_data   = id_rs1_data_i;
            id_d.rs2_data   = id_rs2_data_i;
            id_d.imm        = id_imm_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            ex_q <= '0;
        else
            ex_q <= id_d;
    end

    forwarding_unit #(.RA_W(RA_W)) u_forwarding_unit (
        .ex_valid      (ex_q.valid),
        .ex_rs1        (ex_q.rs1),
        .ex_rs2        (ex_q.rs2),
        .mem_reg_write (mem_reg_write_i),
        .mem_rd        (mem_rd_addr_i),
        .wb_reg_write  (wb_reg_write_i),
        .wb_rd         (wb_rd_addr_i),
        .fwd_a         (fwd_a_o),
        .fwd_b         (fwd_b_o)
    );

    always_comb begin
        case (fwd_a_o)
            FWD_MEM: ex_data1_o = mem_alu_result_i;
            FWD_WB:  ex_data1_o = wb_data_i;
            default: ex_data1_o = ex_q.rs1_data;
        endcase
        case (fwd_b_o)
            FWD_MEM: fwd_b_data = mem_alu_result_i;
            FWD_WB:  fwd_b_data = wb_data_i;
            default: fwd_b_data = ex_q.rs2_data;
        endcase
    end

    assign ex_data2_o      = ex_q.alu_src ? ex_q.imm : fwd_b_data;
    assign ex_store_data_o = fwd_b_data;
    assign ex_alu_op_o     = ex_q.alu_op;
    assign ex_rd_addr_o    = ex_q.rd;
    assign ex_valid_o      = ex_q.valid;
    assign ex_reg_write_o  = ex_q.reg_write;
    assign ex_mem_to_reg_o = ex_q.mem_to_reg;
    assign ex_mem_read_o   = ex_q.mem_read;
    assign ex_mem_write_o  = ex_q.mem_write;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - scoreboard bench for id_ex_operand_stage
module tb_id_ex_operand_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i, flush_i, id_valid_i;
    logic [31:0] id_rs1_data_i, id_rs2_data_i, id_imm_i;
    logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
    logic [2:0]  id_alu_op_i;
    logic        id_alu_src_i, id_reg_write_i, id_mem_to_reg_i, id_mem_read_i, id_mem_write_i;
    logic        mem_reg_write_i, wb_reg_write_i;
    logic [4:0]  mem_rd_addr_i, wb_rd_addr_i;
    logic [31:0] mem_alu_result_i, wb_data_i;
    logic        stall_o;
    logic [31:0] ex_data1_o, ex_data2_o, ex_store_data_o;
    logic [2:0]  ex_alu_op_o;
    logic [4:0]  ex_rd_addr_o;
    logic        ex_valid_o, ex_reg_write_o, ex_mem_to_reg_o, ex_mem_read_o, ex_mem_write_o;
    logic [1:0]  fwd_a_o, fwd_b_o;

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .id_valid_i(id_valid_i),
        .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i), .id_rd_addr_i(id_rd_addr_i),
        .id_alu_op_i(id_alu_op_i), .id_alu_src_i(id_alu_src_i), .id_reg_write_i(id_reg_write_i),
        .id_mem_to_reg_i(id_mem_to_reg_i), .id_mem_read_i(id_mem_read_i), .id_mem_write_i(id_mem_write_i),
        .mem_reg_write_i(mem_reg_write_i), .mem_rd_addr_i(mem_rd_addr_i), .mem_alu_result_i(mem_alu_result_i),
        .wb_reg_write_i(wb_reg_write_i), .wb_rd_addr_i(wb_rd_addr_i), .wb_data_i(wb_data_i),
        .stall_o(stall_o), .ex_data1_o(ex_data1_o), .ex_data2_o(ex_data2_o), .ex_alu_op_o(ex_alu_op_o),
        .ex_store_data_o(ex_store_data_o), .ex_rd_addr_o(ex_rd_addr_o), .ex_valid_o(ex_valid_o),
        .ex_reg_write_o(ex_reg_write_o), .ex_mem_to_reg_o(ex_mem_to_reg_o), .ex_mem_read_o(ex_mem_read_o),
        .ex_mem_write_o(ex_mem_write_o), .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o)
    );

    typedef struct {
        logic        valid;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic [2:0]  op;
        logic        src, rw, m2r, mr, mw;
    } ins_t;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } wp_t;

    typedef struct {
        logic [31:0] d1, d2, sd;
        logic [2:0]  op;
        logic [4:0]  rd;
        logic [1:0]  fa, fb;
        logic        rw, m2r, mr, mw;
    } out_t;

    typedef struct {
        logic valid;
        logic stall;
    } cyc_t;

    out_t outq[$];
    cyc_t cycq[$];
    ins_t slot;
    int   total = 0;
    int   bad = 0;
    bit   mon_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic ins_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                                input logic [31:0] imm, input logic [2:0] op, input logic src,
                                input logic rw, input logic m2r, input logic mr, input logic mw);
        ins_t r;
        r.valid = v; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.d1 = d1; r.d2 = d2; r.imm = imm;
        r.op = op; r.src = src; r.rw = rw; r.m2r = m2r; r.mr = mr; r.mw = mw;
        return r;
    endfunction

    function automatic wp_t wp(input logic we, input logic [4:0] rd, input logic [31:0] data);
        wp_t r;
        r.we = we; r.rd = rd; r.data = data;
        return r;
    endfunction

    function automatic ins_t rnd_ins();
        return mk($urandom_range(0, 99) < 85, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), $urandom(), $urandom(), $urandom(), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 9) < 4, 1'($urandom_range(0, 1)));
    endfunction

    function automatic wp_t rnd_wp();
        return wp(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom());
    endfunction

    // Operand source rule: newest writer of a non-zero register wins, else the captured value.
    function automatic logic [33:0] resolve(input logic [4:0] rs, input logic [31:0] rv,
                                            input wp_t m, input wp_t w);
        if (rs != 5'd0 && m.we && m.rd == rs) return {FWD_MEM, m.data};
        if (rs != 5'd0 && w.we && w.rd == rs) return {FWD_WB, w.data};
        return {FWD_REG, rv};
    endfunction

    task automatic drive_id(input ins_t id, input logic flush);
        id_valid_i = id.valid; flush_i = flush;
        id_rs1_addr_i = id.rs1; id_rs2_addr_i = id.rs2; id_rd_addr_i = id.rd;
        id_rs1_data_i = id.d1; id_rs2_data_i = id.d2; id_imm_i = id.imm;
        id_alu_op_i = id.op; id_alu_src_i = id.src; id_reg_write_i = id.rw;
        id_mem_to_reg_i = id.m2r; id_mem_read_i = id.mr; id_mem_write_i = id.mw;
    endtask

    // One cycle: mem/wb apply to whatever sits in EX now, id is presented for capture.
    task automatic step(input ins_t id, input logic flush, input wp_t m, input wp_t w, output logic stall);
        out_t        o;
        cyc_t        c;
        logic [33:0] a, b;
        @(posedge clk); #1;
        mem_reg_write_i = m.we; mem_rd_addr_i = m.rd; mem_alu_result_i = m.data;
        wb_reg_write_i = w.we; wb_rd_addr_i = w.rd; wb_data_i = w.data;
        if (slot.valid) begin
            a = resolve(slot.rs1, slot.d1, m, w);
            b = resolve(slot.rs2, slot.d2, m, w);
            o.d1 = a[31:0]; o.sd = b[31:0]; o.d2 = slot.src ? slot.imm : b[31:0];
            o.fa = a[33:32]; o.fb = b[33:32]; o.op = slot.op; o.rd = slot.rd;
            o.rw = slot.rw; o.m2r = slot.m2r; o.mr = slot.mr; o.mw = slot.mw;
            outq.push_back(o);
        end
        drive_id(id, flush);
        stall = slot.valid && slot.mr && slot.rd != 5'd0 && id.valid && !flush
                && (slot.rd == id.rs1 || slot.rd == id.rs2);
        c.valid = slot.valid;
        c.stall = stall;
        cycq.push_back(c);
        if (id.valid && !flush && !stall) slot = id;
        else slot.valid = 1'b0;
        mon_on = 1'b1;
    endtask

    initial begin : monitor
        cyc_t c;
        out_t o;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (cycq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL cyc_queue: no expectation for this cycle");
                end else begin
                    c = cycq.pop_front();
                    chk("stall", 32'(stall_o), 32'(c.stall));
                    chk("valid", 32'(ex_valid_o), 32'(c.valid));
                end
                if (ex_valid_o) begin
                    if (outq.size() == 0) begin
                        total++; bad++;
                        $display("FAIL out_queue: ex_valid_o with nothing expected");
                    end else begin
                        o = outq.pop_front();
                        chk("data1", ex_data1_o, o.d1);
                        chk("data2", ex_data2_o, o.d2);
                        chk("store_data", ex_store_data_o, o.sd);
                        chk("alu_op", 32'(ex_alu_op_o), 32'(o.op));
                        chk("rd", 32'(ex_rd_addr_o), 32'(o.rd));
                        chk("fwd", 32'({fwd_a_o, fwd_b_o}), 32'({o.fa, o.fb}));
                        chk("ctrl", 32'({ex_reg_write_o, ex_mem_to_reg_o, ex_mem_read_o, ex_mem_write_o}),
                            32'({o.rw, o.m2r, o.mr, o.mw}));
                    end
                end else begin
                    chk("bubble_ctrl", 32'({ex_reg_write_o, ex_mem_to_reg_o, ex_mem_read_o, ex_mem_write_o}), 32'd0);
                    chk("bubble_fwd", 32'({fwd_a_o, fwd_b_o}), 32'd0);
                end
            end
        end
    end

    initial begin : stimulus
        logic st;
        ins_t cur;
        ins_t nop;
        wp_t  idle;
        nop  = mk(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0);
        idle = wp(0, 5'd0, 32'd0);
        slot = nop;
        rst_i = 1'b1;
        drive_id(nop, 1'b0);
        mem_reg_write_i = 0; mem_rd_addr_i = 0; mem_alu_result_i = 0;
        wb_reg_write_i = 0; wb_rd_addr_i = 0; wb_data_i = 0;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;

        // Asynchronous reset while a valid instruction sits in EX
        drive_id(mk(1, 5'd1, 5'd2, 5'd9, 32'd5, 32'd7, 32'd0, ALU_ADD, 0, 1, 0, 1, 0), 1'b0);
        @(posedge clk); #2;
        chk("pre_reset_valid", 32'(ex_valid_o), 32'd1);
        chk("pre_reset_rd", 32'(ex_rd_addr_o), 32'd9);
        rst_i = 1'b1;
        #1;
        chk("reset_valid", 32'(ex_valid_o), 32'd0);
        chk("reset_ctrl", 32'({ex_reg_write_o, ex_mem_read_o}), 32'd0);
        chk("reset_alu_op", 32'(ex_alu_op_o), 32'd0);
        chk("reset_rd", 32'(ex_rd_addr_o), 32'd0);
        chk("reset_stall", 32'(stall_o), 32'd0);
        drive_id(nop, 1'b0);
        @(negedge clk) rst_i = 1'b0;

        // Plain pass, double forward (MEM wins, then WB with mem_rd=x0)
        step(mk(1, 5'd1, 5'd2, 5'd8, 32'd5, 32'd7, 32'd0, ALU_ADD, 0, 1, 0, 0, 0), 0, idle, idle, st);
        step(mk(1, 5'd3, 5'd3, 5'd4, 32'd0, 32'd0, 32'd0, ALU_SUB, 0, 1, 0, 0, 0), 0, idle, idle, st);
        step(mk(1, 5'd3, 5'd3, 5'd4, 32'd0, 32'd0, 32'd0, ALU_SUB, 0, 1, 0, 0, 0), 0,
             wp(1, 5'd3, 32'h11), wp(1, 5'd3, 32'h22), st);
        // Load-use: LW x5 then ADD x6,x5,x1 (stall, bubble, re-enter forwarded from WB)
        step(mk(1, 5'd2, 5'd0, 5'd5, 32'd0, 32'd0, 32'd4, ALU_ADD, 1, 1, 1, 1, 0), 0,
             wp(1, 5'd0, 32'h11), wp(1, 5'd3, 32'h22), st);
        step(mk(1, 5'd5, 5'd1, 5'd6, 32'd0, 32'd5, 32'd0, ALU_ADD, 0, 1, 0, 0, 0), 0, idle, idle, st);
        step(mk(1, 5'd5, 5'd1, 5'd6, 32'd0, 32'd5, 32'd0, ALU_ADD, 0, 1, 0, 0, 0), 0, idle, idle, st);
        // Flush beats load-use
        step(mk(1, 5'd2, 5'd0, 5'd5, 32'd0, 32'd0, 32'd4, ALU_ADD, 1, 1, 1, 1, 0), 0,
             idle, wp(1, 5'd5, 32'hBEEF), st);
        step(mk(1, 5'd5, 5'd1, 5'd6, 32'd0, 32'd5, 32'd0, ALU_ADD, 0, 1, 0, 0, 1), 1, idle, idle, st);
        // Store with immediate, rs2 forwarded from MEM
        step(mk(1, 5'd2, 5'd7, 5'd0, 32'd3, 32'd1, 32'h10, ALU_ADD, 1, 0, 0, 0, 1), 0, idle, idle, st);
        step(nop, 0, wp(1, 5'd7, 32'hABCD), idle, st);

        st = 1'b0;
        cur = nop;
        for (int i = 0; i < 600; i++) begin
            if (!st) begin
                cur = rnd_ins();
                if (slot.valid && slot.mr && $urandom_range(0, 1) == 1) cur.rs2 = slot.rd;
            end
            step(cur, $urandom_range(0, 9) == 0, rnd_wp(), rnd_wp(), st);
        end

        @(negedge clk);
        #1 mon_on = 1'b0;
        chk("out_queue_drained", 32'(outq.size()), 32'd0);
        chk("cyc_queue_drained", 32'(cycq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
